// File: rtl/serializer_pkg.sv
// serializer_pkg: shared FSM encoding and counter sizing for piso_serializer
package serializer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int GCNT_W = 4;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: one-word buffered parallel-in/serial-out stage with frame marker
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GCNT_W-1:0]  gcnt_q, gcnt_d;
    logic               accept, load, ser_bit;
    logic [WIDTH-1:0]   sreg_shifted;

    assign accept       = in_valid && !hold_full_q;
    assign ser_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE:  load = hold_full_q;
            SHIFT: begin
                if (cnt_q != LAST) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    gcnt_d  = GAP_LOAD;
                end else if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gcnt_q != '0) begin
                    gcnt_d = gcnt_q - 1'b1;
                end else if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a load can only happen with the buffer full, so it never races an accept
        if (load) begin
            state_d = SHIFT;
            sreg_d  = hold_q;
            cnt_d   = '0;
        end
        hold_d      = accept ? in_data : hold_q;
        hold_full_d = load ? 1'b0 : (accept ? 1'b1 : hold_full_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            gcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign dout_valid  = (state_q == SHIFT);
    assign dout        = dout_valid && ser_bit;
    assign frame_start = dout_valid && (cnt_q == '0);
    assign busy        = (state_q != IDLE) || hold_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and randomized checks of three serializer configurations
module tb_piso_serializer;
    logic       clk;
    logic       rst_n;
    logic [3:0] id   [3];
    logic       iv   [3];
    logic       rdy  [3];
    logic       dout [3];
    logic       dv   [3];
    logic       fs   [3];
    logic       busy [3];
    logic [3:0] q_ds;

    int vectors = 0;
    int miscompares = 0;

    logic exp_b [3][1024];
    logic obs_b [3][1024];
    int   exp_n [3];
    int   obs_n [3] = '{0, 0, 0};
    int   base  [3];

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
        .clk(clk), .rst(rst_n), .in_data(id[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .dout(dout[0]), .dout_valid(dv[0]), .frame_start(fs[0]), .busy(busy[0]));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst(rst_n), .in_data(id[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .dout(dout[1]), .dout_valid(dv[1]), .frame_start(fs[1]), .busy(busy[1]));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u2 (
        .clk(clk), .rst(rst_n), .in_data(id[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
        .dout(dout[2]), .dout_valid(dv[2]), .frame_start(fs[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream 4-bit serial-in register fed by instance 0
    always @(posedge clk or negedge rst_n)
        if (!rst_n) q_ds <= '0;
        else if (dv[0]) q_ds <= {q_ds[2:0], dout[0]};

    always @(negedge clk)
        for (int i = 0; i < 3; i++)
            if (dv[i] === 1'b1 && obs_n[i] < 1024) begin
                obs_b[i][obs_n[i]] <= dout[i];
                obs_n[i] <= obs_n[i] + 1;
            end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  w;
        logic [7:0]  pair;
        logic [11:0] seq;
        bit          gap;
        int          bi;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            id[i] = '0;
        end
        #3;
        chk("rst_ready", rdy[0], 1);
        chk("rst_dv", dv[0], 0);
        chk("rst_dout", dout[0], 0);
        chk("rst_fs", fs[0], 0);
        chk("rst_busy", busy[0], 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // single MSB-first word
        w = 4'b1011;
        id[0] = w;
        iv[0] = 1'b1;
        cyc();
        iv[0] = 1'b0;
        chk("t1_ready_full", rdy[0], 0);
        chk("t1_busy_buffered", busy[0], 1);
        chk("t1_dv_before_load", dv[0], 0);
        cyc();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t1_dv%0d", b), dv[0], 1);
            chk($sformatf("t1_dout%0d", b), dout[0], w[3-b]);
            chk($sformatf("t1_fs%0d", b), fs[0], b == 0);
            cyc();
        end
        chk("t1_dv_after", dv[0], 0);
        chk("t1_busy_after", busy[0], 0);
        chk("t1_downstream_q", q_ds, 4'b1011);
        cyc();

        // single LSB-first word
        w = 4'b0001;
        id[1] = w;
        iv[1] = 1'b1;
        cyc();
        iv[1] = 1'b0;
        cyc();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t2_dv%0d", b), dv[1], 1);
            chk($sformatf("t2_dout%0d", b), dout[1], w[b]);
            cyc();
        end
        chk("t2_dv_after", dv[1], 0);
        cyc();

        // back-to-back streaming without bubbles
        pair = 8'hA5;
        id[0] = 4'hA;
        iv[0] = 1'b1;
        cyc();
        chk("t3_ready_full", rdy[0], 0);
        id[0] = 4'h5;
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_dv%0d", i), dv[0], 1);
            chk($sformatf("t3_dout%0d", i), dout[0], pair[7-i]);
            chk($sformatf("t3_fs%0d", i), fs[0], i == 0 || i == 4);
            if (i == 0) chk("t3_ready_after_load", rdy[0], 1);
            if (i == 1) begin
                chk("t3_ready_refull", rdy[0], 0);
                iv[0] = 1'b0;
            end
            if (i == 4) chk("t3_ready_after_reload", rdy[0], 1);
            cyc();
        end
        chk("t3_dv_after", dv[0], 0);
        chk("t3_busy_after", busy[0], 0);
        cyc();

        // two gap cycles between queued words
        pair = 8'h96;
        id[2] = 4'h9;
        iv[2] = 1'b1;
        cyc();
        id[2] = 4'h6;
        cyc();
        chk("t4_ready", rdy[2], 1);
        for (int i = 0; i < 12; i++) begin
            gap = (i == 4 || i == 5 || i == 10 || i == 11);
            bi = (i < 4) ? i : i - 2;
            chk($sformatf("t4_dv%0d", i), dv[2], !gap);
            if (!gap) chk($sformatf("t4_dout%0d", i), dout[2], pair[7-bi]);
            chk($sformatf("t4_fs%0d", i), fs[2], i == 0 || i == 6);
            chk($sformatf("t4_busy%0d", i), busy[2], 1);
            if (i == 1) iv[2] = 1'b0;
            cyc();
        end
        chk("t4_busy_after", busy[2], 0);
        chk("t4_dv_after", dv[2], 0);
        cyc();

        // third word held off while buffer is full
        seq = 12'h3CF;
        id[0] = 4'h3;
        iv[0] = 1'b1;
        cyc();
        id[0] = 4'hC;
        cyc();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t5_dv%0d", i), dv[0], 1);
            chk($sformatf("t5_dout%0d", i), dout[0], seq[11-i]);
            if (i == 1) id[0] = 4'hF;
            if (i >= 1 && i <= 3) chk($sformatf("t5_ready_blocked%0d", i), rdy[0], 0);
            if (i == 4) chk("t5_ready_freed", rdy[0], 1);
            if (i == 5) iv[0] = 1'b0;
            cyc();
        end
        chk("t5_dv_after", dv[0], 0);
        cyc();

        // asynchronous reset in the middle of a word
        id[0] = 4'b1100;
        iv[0] = 1'b1;
        cyc();
        iv[0] = 1'b0;
        cyc();
        chk("t6_bit0", dout[0], 1);
        cyc();
        chk("t6_bit1", dout[0], 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_dv", dv[0], 0);
        chk("t6_async_dout", dout[0], 0);
        chk("t6_async_busy", busy[0], 0);
        chk("t6_async_ready", rdy[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("t6_no_residue%0d", i), dv[0], 0);
            chk($sformatf("t6_idle_busy%0d", i), busy[0], 0);
            chk($sformatf("t6_idle_ready%0d", i), rdy[0], 1);
        end

        // random traffic on all three configurations against a bit-stream model
        for (int i = 0; i < 3; i++) begin
            base[i] = obs_n[i];
            exp_n[i] = obs_n[i];
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                id[i] = 4'($urandom);
                iv[i] = ($urandom_range(0, 2) != 0);
                if (iv[i] && rdy[i] && exp_n[i] < 1020)
                    for (int b = 0; b < 4; b++) begin
                        exp_b[i][exp_n[i]] = (i == 1) ? id[i][b] : id[i][3-b];
                        exp_n[i]++;
                    end
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        for (int t = 0; t < 200 && (busy[0] || busy[1] || busy[2]); t++) cyc();
        chk("rnd_drain_busy", {busy[0], busy[1], busy[2]}, 0);
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rnd_count_u%0d", i), obs_n[i] - base[i], exp_n[i] - base[i]);
            for (int k = base[i]; k < exp_n[i] && k < obs_n[i]; k++)
                chk($sformatf("rnd_u%0d_bit%0d", i, k - base[i]), obs_b[i][k], exp_b[i][k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that feeds the 4-bit serial-in shift register's `din`. It accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and emits each word one bit per clock with a valid strobe and a frame-start marker. With GAP_CYCLES = 0 it streams back-to-back words without bubbles. With the defaults, the downstream 4-bit register holds the accepted word after four shifts.

## Interface
- WIDTH, 4: word width in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 1: 1 sends in_data[WIDTH-1] first; 0 sends bit 0 first.
- GAP_CYCLES, 0: idle cycles inserted after each word; legal range is 0–15.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding buffer empty; driven directly from a register.
- dout  output  1  serial bit; connects to the downstream `din`.
- dout_valid  output  1  dout carries a data bit this cycle.
- frame_start  output  1  high with the first bit of each word.
- busy  output  1  high when state ≠ IDLE or the holding buffer is full.

## Operation
- Storage:
  - hold register plus hold_full flag;
  - shift register sreg;
  - bit counter cnt (clog2(WIDTH) bits);
  - gap counter gcnt (4 bits).
- Accept: in_valid && in_ready at a rising edge writes in_data into hold and sets hold_full.
  - in_ready = !hold_full; it has no combinational path from in_valid.
- States and transitions:
  - IDLE → SHIFT when hold_full. Load sreg from hold, clear hold_full, cnt = 0.
  - SHIFT, cnt < WIDTH-1: shift sreg by one (direction per MSB_FIRST), cnt += 1.
  - SHIFT, cnt = WIDTH-1, GAP_CYCLES > 0: go to GAP, gcnt = GAP_CYCLES-1.
  - SHIFT, cnt = WIDTH-1, GAP_CYCLES = 0, hold_full: stay in SHIFT and reload from hold (no bubble).
  - SHIFT, cnt = WIDTH-1, GAP_CYCLES = 0, hold empty: go to IDLE.
  - GAP, gcnt = 0: go to SHIFT with reload if hold_full, else go to IDLE.
  - GAP, gcnt > 0: gcnt -= 1.
- Outputs:
  - dout_valid = (state == SHIFT).
  - dout = current serial bit of sreg when dout_valid is high, else 0.
  - frame_start = dout_valid && cnt == 0.
- A word accepted while a load occurs in the same edge is not possible: hold_full is already set at any edge where a load happens.
- in_data is ignored when in_ready = 0. in_valid may drop without penalty; there is no stall on the serial side.

## Timing
- Reset (rst low) takes effect asynchronously:
  - state = IDLE, hold_full = 0, sreg = 0, cnt = 0, gcnt = 0;
  - in_ready = 1, dout = 0, dout_valid = 0, frame_start = 0, busy = 0.
- Reset mid-word or mid-gap drops dout_valid immediately and discards both the buffered and the in-flight word. The first accept is possible at the first rising edge after rst returns high.
- Latency, from an accept at edge k with the block IDLE:
  - load at edge k+1;
  - first bit valid in the cycle after edge k+1;
  - last bit valid in the cycle after edge k+WIDTH.
- Streaming with GAP_CYCLES = 0:
  - the next word may be accepted at edge k+2 or later;
  - dout_valid stays continuously high while in_valid is held;
  - sustained throughput is one word per WIDTH cycles.
- With GAP_CYCLES = G, exactly G cycles with dout_valid = 0 separate consecutive words.
- busy stays high until the cycle after the last bit (or the last gap cycle) with no word pending.

## Structure
- The shared package `serializer_pkg` holds:
  - state encoding localparams (IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2);
  - the clog2-based counter-width constant.
- No sub-module is needed; the block is a single module with one FSM, one datapath register pair and two counters.

## Test plan
- Reset, then a single word 4'b1011 with MSB_FIRST = 1:
  - dout = 1, 0, 1, 1 on four consecutive valid cycles;
  - frame_start high only on the first bit;
  - downstream Q = 4'b1011 afterwards.
- MSB_FIRST = 0 with word 4'b0001: dout = 1, 0, 0, 0.
- Back-to-back words 4'hA then 4'h5 with in_valid held high and GAP_CYCLES = 0:
  - 8 consecutive dout_valid cycles, bits 1010 0101;
  - in_ready deasserts once the buffer fills and reasserts after each load.
- GAP_CYCLES = 2 with two words queued: exactly 2 cycles of dout_valid = 0 between the words; busy stays high through the gap.
- Buffer full: in_valid held with a third word 4'hF while one word is shifting and one is buffered → in_ready = 0, and 4'hF is not accepted until the buffered word is loaded.
- Reset asserted after the 2nd bit of 4'b1100:
  - dout_valid and dout go to 0 immediately, without waiting for a clock edge;
  - after release: in_ready = 1, busy = 0, and no residual bits are emitted.
